// File: rtl/sysarr_add_arbiter.sv
// Round-robin arbiter that time-shares one combinational adder among N_REQ
// requesters and returns each sum through a one-entry valid/ready result register.
module sysarr_add_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          nRST,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*DATA_W-1:0]       req_op1,
   input  logic [N_REQ*DATA_W-1:0]       req_op2,
   output logic [DATA_W-1:0]             add_input1,
   output logic [DATA_W-1:0]             add_input2,
   input  logic [DATA_W-1:0]             add_output,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [$clog2(N_REQ)-1:0]      res_id,
   output logic [DATA_W-1:0]             res_data,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   logic [ID_W-1:0]   r_rrPtr;
   logic              r_resValid;
   logic [ID_W-1:0]   r_resId;
   logic [DATA_W-1:0] r_resData;
   logic [CNT_W-1:0]  r_stallCnt;

   logic              w_canIssue;
   logic              w_grantValid;
   logic [ID_W-1:0]   w_grantIdx;
   logic [N_REQ-1:0]  w_reqReady;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic [ID_W-1:0]   w_cand;

   assign w_canIssue = !r_resValid || res_ready;

   // Walk the ring from the pointer; the wrap is an explicit compare so that
   // non-power-of-two requester counts never visit an out-of-range index.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      w_reqReady   = '0;
      w_op1        = '0;
      w_op2        = '0;
      w_cand       = r_rrPtr;
      for (int off = 0; off < N_REQ; off++) begin
         if (nRST && w_canIssue && !w_grantValid && req_valid[w_cand]) begin
            w_grantValid       = 1'b1;
            w_grantIdx         = w_cand;
            w_reqReady[w_cand] = 1'b1;
            w_op1              = req_op1[w_cand*DATA_W +: DATA_W];
            w_op2              = req_op2[w_cand*DATA_W +: DATA_W];
         end
         w_cand = (w_cand == LAST_ID) ? '0 : w_cand + 1'b1;
      end
   end

   // Result slot: a refill takes priority over a drain so back-to-back
   // transfers keep res_valid high at one result per cycle.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_rrPtr    <= '0;
         r_resValid <= 1'b0;
         r_resId    <= '0;
         r_resData  <= '0;
      end else if (w_grantValid) begin
         r_resValid <= 1'b1;
         r_resId    <= w_grantIdx;
         r_resData  <= add_output;
         r_rrPtr    <= (w_grantIdx == LAST_ID) ? '0 : w_grantIdx + 1'b1;
      end else if (r_resValid && res_ready) begin
         r_resValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_stallCnt <= '0;
      end else if ((|req_valid) && !(|w_reqReady) && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

   assign req_ready  = w_reqReady;
   assign add_input1 = w_op1;
   assign add_input2 = w_op2;
   assign res_valid  = r_resValid;
   assign res_id     = r_resId;
   assign res_data   = r_resData;
   assign stall_cnt  = r_stallCnt;

endmodule
